// File: rtl/y_arith_pkg.sv
// y_arith_pkg: shared constants for the y_arith adder/subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   CTRL_ADD/SUB  : encodings of the ctrl operation select
package y_arith_pkg;
    localparam int   DEFAULT_WIDTH = 32;
    localparam logic CTRL_ADD      = 1'b0;
    localparam logic CTRL_SUB      = 1'b1;
endpackage

// File: rtl/y_adder1.sv
// y_adder1: one-bit full adder, one stage of the ripple-carry chain.
//   a, b  : operand bits
//   cin   : carry in from the previous stage
//   z     : sum bit
//   cout  : carry out to the next stage
module y_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic z,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign z    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/y_arith.sv
// y_arith: WIDTH-bit two's-complement adder/subtractor.
//   clk, rst         : system clock, synchronous active-high reset (registers only)
//   a, b             : operands
//   ctrl             : 0 = a+b, 1 = a-b
//   z, cout          : combinational result and carry-out (cout=1 means no borrow on subtract)
//   z_r, cout_r      : registered copies of z and cout
//   ovf_r, zero_r    : registered signed-overflow and all-zero flags
module y_arith
    import y_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic [WIDTH-1:0] z_r,
    output logic             cout_r,
    output logic             ovf_r,
    output logic             zero_r
);
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   c;
    logic             ovf;
    logic             zero;

    logic [WIDTH-1:0] z_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign b_x  = b ^ {WIDTH{ctrl == CTRL_SUB}};
    assign c[0] = (ctrl == CTRL_ADD) ? 1'b0 : 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        y_adder1 u_add (
            .a    (a[i]),
            .b    (b_x[i]),
            .cin  (c[i]),
            .z    (z[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[WIDTH];
    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign ovf  = c[WIDTH-1] ^ c[WIDTH];
    assign zero = ~|z;

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            z_q    <= z;
            cout_q <= cout;
            ovf_q  <= ovf;
            zero_q <= zero;
        end
    end

    assign z_r    = z_q;
    assign cout_r = cout_q;
    assign ovf_r  = ovf_q;
    assign zero_r = zero_q;
endmodule

// File: tb/tb_y_arith.sv
module tb_y_arith;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        ctrl;
    logic [31:0] z, z_r;
    logic        cout, cout_r, ovf_r, zero_r;

    int n_cmp = 0;
    int n_err = 0;

    y_arith #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .ctrl   (ctrl),
        .z      (z),
        .cout   (cout),
        .z_r    (z_r),
        .cout_r (cout_r),
        .ovf_r  (ovf_r),
        .zero_r (zero_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                         output logic [31:0] ez, output logic ec, output logic eo, output logic ezr);
        longint unsigned ua, ub;
        longint sa, sb, sr;
        ua = {32'b0, ma};
        ub = {32'b0, mb};
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (mc) begin
            ez = ma - mb;
            ec = (ua >= ub);
            sr = sa - sb;
        end else begin
            ez = ma + mb;
            ec = ((ua + ub) > 64'hFFFF_FFFF);
            sr = sa + sb;
        end
        eo  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        ezr = (ez == 32'd0);
    endtask

    task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tc, input logic trst);
        logic [31:0] ez;
        logic ec, eo, ezr;
        @(negedge clk);
        a = ta; b = tb_v; ctrl = tc; rst = trst;
        #1;
        model(ta, tb_v, tc, ez, ec, eo, ezr);
        chk({tag, ".z"}, z, ez);
        chk({tag, ".cout"}, {31'b0, cout}, {31'b0, ec});
        @(posedge clk);
        #1;
        if (trst) begin
            ez = '0; ec = 1'b0; eo = 1'b0; ezr = 1'b0;
        end
        chk({tag, ".z_r"}, z_r, ez);
        chk({tag, ".cout_r"}, {31'b0, cout_r}, {31'b0, ec});
        chk({tag, ".ovf_r"}, {31'b0, ovf_r}, {31'b0, eo});
        chk({tag, ".zero_r"}, {31'b0, zero_r}, {31'b0, ezr});
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; ctrl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.z_r", z_r, 32'h0);
        chk("reset.flags", {29'b0, cout_r, ovf_r, zero_r}, 32'h0);

        // Directed boundaries
        step("add_carry",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("add_carry.zero_r_direct", {31'b0, zero_r}, 32'h1);
        chk("add_carry.cout_r_direct", {31'b0, cout_r}, 32'h1);
        step("sub_borrow", 32'h0, 32'h1, 1'b1, 1'b0);
        chk("sub_borrow.z_direct", z_r, 32'hFFFF_FFFF);
        step("sub_5_3",    32'd5, 32'd3, 1'b1, 1'b0);
        chk("sub_5_3.z_direct", z_r, 32'd2);
        step("ovf_add",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("ovf_add.ovf_direct", {31'b0, ovf_r}, 32'h1);
        step("ovf_sub",    32'h8000_0000, 32'h1, 1'b1, 1'b0);
        chk("ovf_sub.z_direct", z_r, 32'h7FFF_FFFF);
        step("sub_equal",  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        chk("sub_equal.zero_direct", {31'b0, zero_r}, 32'h1);

        // Reset mid-operation: registers clear, combinational path keeps tracking.
        step("rst_hold",   32'd3, 32'd4, 1'b0, 1'b1);
        chk("rst_hold.z_direct", z, 32'd7);
        step("rst_release", 32'd3, 32'd4, 1'b0, 1'b0);
        chk("rst_release.z_r_direct", z_r, 32'd7);

        // Random sweep
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 8 == 7) ? ra : $urandom;
            step("random", ra, rb, 1'($urandom % 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
